// File: rtl/ser2para_sync_pkg.sv
// Constants and types shared by the serial frame receiver.
// The transmit serializer builds its frames from the same constants.
package ser2para_sync_pkg;

  localparam int FRAME_W   = 40;
  localparam int SYNC_W    = 8;
  localparam int BIT_CNT_W = 6;
  localparam int DIV_CNT_W = 14;
  localparam int CNT_W     = 4;

  localparam logic [SYNC_W-1:0] DEF_SYNC_WORD = 8'hA5;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCK   = 2'd2
  } state_e;

endpackage

// File: rtl/ser2para_sync_bit_sampler.sv
// Synchronises the serial input and produces one mid-bit sample strobe per bit.
// Every input transition re-centres the bit-period counter on the new bit.
module ser2para_sync_bit_sampler
  import ser2para_sync_pkg::*;
#(
  parameter logic [DIV_CNT_W-1:0] DIV = 14'd10000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ser_i,
  output logic sync_bit_o,
  output logic samp_stb_o
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV - 1'b1;
  localparam logic [DIV_CNT_W-1:0] DIV_MID  = (DIV >> 1) - 1'b1;

  logic                 meta_q;
  logic                 sync_q;
  logic                 prev_q;
  logic [DIV_CNT_W-1:0] div_cnt_q;
  logic [DIV_CNT_W-1:0] div_cnt_d;
  logic                 edge_det;

  // NOTE: asynchronous active-low reset; every flop, including the synchronizer, clears on it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q    <= 1'b0;
      sync_q    <= 1'b0;
      prev_q    <= 1'b0;
      div_cnt_q <= '0;
    end else begin
      meta_q    <= ser_i;
      sync_q    <= meta_q;
      prev_q    <= sync_q;
      div_cnt_q <= div_cnt_d;
    end
  end

  assign edge_det = sync_q ^ prev_q;

  // NOTE: the default comes first so every path assigns div_cnt_d and no latch is inferred.
  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (edge_det || (div_cnt_q == DIV_LAST)) begin
      div_cnt_d = '0;
    end
  end

  // An edge wins over the sample: the counter restarts and this strobe is dropped.
  assign samp_stb_o = (div_cnt_q == DIV_MID) && !edge_det;
  assign sync_bit_o = sync_q;

endmodule

// File: rtl/ser2para_sync.sv
// Serial-to-parallel frame receiver: sync-word search, lock verification and
// loss-of-lock detection on top of the mid-bit sampler.
module ser2para_sync
  import ser2para_sync_pkg::*;
#(
  parameter logic [DIV_CNT_W-1:0] DIV       = 14'd10000,
  parameter logic [SYNC_W-1:0]    SYNC_WORD = DEF_SYNC_WORD,
  parameter int                   LOCK_CNT  = 2,
  parameter int                   MISS_MAX  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ser_i,
  output logic [FRAME_W-1:0] para_o,
  output logic               para_vld,
  output logic               locked,
  output logic               frame_err
);

  localparam logic [CNT_W-1:0]     LOCK_CNT_C = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0]     MISS_MAX_C = CNT_W'(MISS_MAX);
  localparam logic [BIT_CNT_W-1:0] BIT_LAST   = BIT_CNT_W'(FRAME_W - 1);

  logic                 sync_bit;
  logic                 samp_stb;
  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   sr_q, sr_d, sr_n;
  logic [FRAME_W-1:0]   para_q, para_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     hits_q, hits_d;
  logic [CNT_W-1:0]     miss_q, miss_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;
  logic                 hdr_ok;
  logic                 frame_end;

  ser2para_sync_bit_sampler #(
    .DIV (DIV)
  ) u_bit_sampler (
    .clk        (clk),
    .rst_n      (rst_n),
    .ser_i      (ser_i),
    .sync_bit_o (sync_bit),
    .samp_stb_o (samp_stb)
  );

  // Header checks look at the register contents as they will be after this sample.
  assign sr_n      = {sr_q[FRAME_W-2:0], sync_bit};
  assign hdr_ok    = (sr_n[FRAME_W-1 -: SYNC_W] == SYNC_WORD);
  assign frame_end = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    para_d    = para_q;
    bit_cnt_d = bit_cnt_q;
    hits_d    = hits_q;
    miss_d    = miss_q;
    vld_d     = 1'b0;
    err_d     = 1'b0;
    if (samp_stb) begin
      sr_d      = sr_n;
      bit_cnt_d = frame_end ? '0 : bit_cnt_q + 1'b1;
      unique case (state_q)
        ST_SEARCH: begin
          bit_cnt_d = '0;
          if (hdr_ok) begin
            hits_d = CNT_W'(1);
            miss_d = '0;
            if (LOCK_CNT <= 1) begin
              state_d = ST_LOCK;
              para_d  = sr_n;
              vld_d   = 1'b1;
            end else begin
              state_d = ST_VERIFY;
            end
          end
        end
        ST_VERIFY: begin
          if (frame_end) begin
            if (hdr_ok) begin
              hits_d = hits_q + 1'b1;
              if (hits_d >= LOCK_CNT_C) begin
                state_d = ST_LOCK;
                para_d  = sr_n;
                vld_d   = 1'b1;
                miss_d  = '0;
              end
            end else begin
              state_d = ST_SEARCH;
              hits_d  = '0;
            end
          end
        end
        ST_LOCK: begin
          if (frame_end) begin
            if (hdr_ok) begin
              para_d = sr_n;
              vld_d  = 1'b1;
              miss_d = '0;
            end else begin
              err_d  = 1'b1;
              miss_d = miss_q + 1'b1;
              if (miss_d >= MISS_MAX_C) begin
                state_d = ST_SEARCH;
                hits_d  = '0;
                miss_d  = '0;
              end
            end
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_SEARCH;
      sr_q      <= '0;
      para_q    <= '0;
      bit_cnt_q <= '0;
      hits_q    <= '0;
      miss_q    <= '0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      para_q    <= para_d;
      bit_cnt_q <= bit_cnt_d;
      hits_q    <= hits_d;
      miss_q    <= miss_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
    end
  end

  assign para_o    = para_q;
  assign para_vld  = vld_q;
  assign frame_err = err_q;
  assign locked    = (state_q == ST_LOCK);

endmodule

// File: tb/tb_ser2para_sync.sv
// Directed bench for ser2para_sync: a serializer model drives MSB-first frames
// at DIV=10 and the receiver's lock, frame and error outputs are compared.
`timescale 1ns/1ps
module tb_ser2para_sync;

  localparam logic [13:0] DIV   = 14'd10;
  localparam logic [39:0] FRAME = 40'hA5_1234_5678;
  localparam logic [39:0] BADF  = 40'h00_1234_5678;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ser_i = 1'b0;
  logic [39:0] para_o;
  logic        para_vld;
  logic        locked;
  logic        frame_err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          vld_cnt = 0;
  int          err_cnt = 0;
  logic [39:0] exp_para = '0;
  bit          jit_ph = 1'b0;

  typedef struct {
    logic [39:0] frame;
    int          n_frames;
    bit          jit;
    int          exp_vld;
  } vec_t;

  vec_t vecs[4];

  ser2para_sync #(
    .DIV       (DIV),
    .SYNC_WORD (8'hA5),
    .LOCK_CNT  (2),
    .MISS_MAX  (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ser_i     (ser_i),
    .para_o    (para_o),
    .para_vld  (para_vld),
    .locked    (locked),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every accepted frame must carry the frame currently being transmitted.
  always @(negedge clk) begin
    if (rst_n) begin
      if (para_vld) begin
        vld_cnt++;
        check("para_o_on_vld", para_o, exp_para);
      end
      if (frame_err) err_cnt++;
      if (para_vld || frame_err) check("vld_err_exclusive", {39'b0, para_vld & frame_err}, 40'd0);
    end
  end

  task automatic send_bit(input logic b, input int len);
    ser_i = b;
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [39:0] f, input int hi, input int lo, input bit jit);
    int len;
    for (int i = hi; i >= lo; i--) begin
      len = jit ? (jit_ph ? 11 : 9) : 10;
      jit_ph = ~jit_ph;
      send_bit(f[i], len);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ser_i = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vld_cnt = 0;
    err_cnt = 0;
    jit_ph = 1'b0;
    repeat (50) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{40'hA5_1234_5678, 4, 1'b0, 3};
    vecs[1] = '{40'hA5_00A5_A5A5, 4, 1'b0, 3};
    vecs[2] = '{40'hA5_1234_5678, 21, 1'b1, 20};
    vecs[3] = '{40'hA5_DEAD_BEEF, 3, 1'b0, 2};

    // Reset state and idle line.
    repeat (20) @(posedge clk);
    #1;
    check("rst_para_o", para_o, 40'd0);
    check("rst_para_vld", {39'b0, para_vld}, 40'd0);
    check("rst_locked", {39'b0, locked}, 40'd0);
    check("rst_frame_err", {39'b0, frame_err}, 40'd0);
    rst_n = 1'b1;
    repeat (2000) @(posedge clk);
    #1;
    check("idle_vld_count", vld_cnt, 40'd0);
    check("idle_locked", {39'b0, locked}, 40'd0);
    check("idle_err_count", err_cnt, 40'd0);

    // Continuous clean frames: lock on the second header, one accept per later frame.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      exp_para = vecs[v].frame;
      for (int f = 0; f < vecs[v].n_frames; f++) send_bits(vecs[v].frame, 39, 0, vecs[v].jit);
      check("tbl_vld_count", vld_cnt, vecs[v].exp_vld);
      check("tbl_err_count", err_cnt, 40'd0);
      check("tbl_locked", {39'b0, locked}, 40'd1);
      check("tbl_para_o", para_o, vecs[v].frame);
    end

    // False header 28 bits ahead of the real stream: rejected in VERIFY.
    do_reset();
    exp_para = FRAME;
    send_bits({8'hA5, 32'h0}, 39, 12, 1'b0);
    send_bits(FRAME, 39, 0, 1'b0);
    send_bits(FRAME, 39, 0, 1'b0);
    check("false_hdr_vld_early", vld_cnt, 40'd0);
    check("false_hdr_locked_early", {39'b0, locked}, 40'd0);
    send_bits(FRAME, 39, 0, 1'b0);
    send_bits(FRAME, 39, 0, 1'b0);
    check("false_hdr_vld_count", vld_cnt, 40'd2);
    check("false_hdr_locked", {39'b0, locked}, 40'd1);

    // Single bad header while locked.
    do_reset();
    exp_para = FRAME;
    for (int f = 0; f < 3; f++) send_bits(FRAME, 39, 0, 1'b0);
    send_bits(BADF, 39, 0, 1'b0);
    check("one_bad_err_count", err_cnt, 40'd1);
    check("one_bad_vld_count", vld_cnt, 40'd2);
    check("one_bad_locked", {39'b0, locked}, 40'd1);
    send_bits(FRAME, 39, 0, 1'b0);
    check("one_bad_recover_vld", vld_cnt, 40'd3);
    check("one_bad_recover_err", err_cnt, 40'd1);

    // Three consecutive bad headers drop lock; two good frames relock.
    do_reset();
    exp_para = FRAME;
    send_bits(FRAME, 39, 0, 1'b0);
    send_bits(FRAME, 39, 0, 1'b0);
    send_bits(BADF, 39, 0, 1'b0);
    send_bits(BADF, 39, 0, 1'b0);
    check("miss2_locked", {39'b0, locked}, 40'd1);
    check("miss2_err_count", err_cnt, 40'd2);
    send_bits(BADF, 39, 0, 1'b0);
    check("miss3_locked", {39'b0, locked}, 40'd0);
    check("miss3_err_count", err_cnt, 40'd3);
    send_bits(FRAME, 39, 0, 1'b0);
    check("relock_after1", {39'b0, locked}, 40'd0);
    send_bits(FRAME, 39, 0, 1'b0);
    check("relock_locked", {39'b0, locked}, 40'd1);
    check("relock_vld_count", vld_cnt, 40'd2);

    // Reset pulse mid-frame while locked.
    do_reset();
    exp_para = FRAME;
    for (int f = 0; f < 3; f++) send_bits(FRAME, 39, 0, 1'b0);
    check("pre_rst_locked", {39'b0, locked}, 40'd1);
    send_bits(FRAME, 39, 20, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_para_o", para_o, 40'd0);
    check("midrst_locked", {39'b0, locked}, 40'd0);
    check("midrst_vld", {39'b0, para_vld}, 40'd0);
    check("midrst_err", {39'b0, frame_err}, 40'd0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    vld_cnt = 0;
    err_cnt = 0;
    send_bits(FRAME, 19, 0, 1'b0);
    send_bits(FRAME, 39, 0, 1'b0);
    send_bits(FRAME, 39, 0, 1'b0);
    check("post_rst_locked", {39'b0, locked}, 40'd1);
    check("post_rst_vld_count", vld_cnt, 40'd1);
    check("post_rst_para_o", para_o, FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
